uart_cmd_slave: RTL and testbench



---
 rtl/uart_cmd_slave.sv | 149 ++++++++++++++
 tb/tb_uart_cmd_slave.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_slave.sv
// ---------------------------------------------------------------------------
// uart_cmd_slave
//   Byte-level command responder sitting between a UART rx/tx pair and the
//   internal 8-bit register bus. It decodes host frames (CMD, ADDR[, ARG]),
//   performs single reads, single writes, incrementing burst reads and
//   fixed-address streaming burst reads, and returns read data or
//   ACK/NAK status bytes through the transmitter handshake.
//
// Ports
//   MCLK, reset_n         clock, asynchronous active-low reset
//   rx_data / rx_valid    received byte and its one-cycle strobe
//   tx_data / tx_valid    byte to transmit, held until tx_ready accepts it
//   tx_ready              transmitter accepts when tx_valid && tx_ready
//   reg_addr / reg_wdata  register-bus address and write data
//   reg_we / reg_re       one-cycle write / read strobes
//   reg_rdata             read data, valid the cycle after reg_re
//   busy                  high whenever not IDLE
//   err                   one-cycle pulse on timeout, NAK or dropped byte
// ---------------------------------------------------------------------------
module uart_cmd_slave #(
  parameter int unsigned TIMEOUT  = 100000,
  parameter logic [7:0]  ACK_BYTE = 8'h06,
  parameter logic [7:0]  NAK_BYTE = 8'h15
) (
  input  logic       MCLK,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       err
);

  localparam int unsigned    TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    CMD_READ   = 2'b00,
    CMD_WRITE  = 2'b01,
    CMD_INC    = 2'b10,
    CMD_STREAM = 2'b11
  } cmd_t;

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_ARG, WR_DO, RD_ISSUE, RD_CAP, TX_WAIT, ACK, NAK
  } state_t;

  state_t        state, state_nxt;
  cmd_t          cmd;
  logic [7:0]    count;      // accesses remaining after the current one
  logic [TW-1:0] tmo_cnt;    // cycles since the last frame byte
  logic          nak_err;    // err pulse for the first cycle of NAK

  logic in_frame, rx_take, timeout_hit, illegal_cmd;

  assign in_frame    = (state == GET_ADDR) || (state == GET_ARG);
  assign rx_take     = rx_valid && ((state == IDLE) || in_frame);
  // A byte arriving in the last allowed cycle still counts as on time.
  assign timeout_hit = in_frame && !rx_valid && (tmo_cnt == TMO_LAST);
  assign illegal_cmd = (rx_data[7:2] != 6'd0);

  // State register
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt
    // unassigned and infers a latch.
    state_nxt = state;
    unique case (state)
      IDLE:     if (rx_valid) state_nxt = illegal_cmd ? NAK : GET_ADDR;
      GET_ADDR: if (rx_valid)        state_nxt = (cmd == CMD_READ) ? RD_ISSUE : GET_ARG;
                else if (timeout_hit) state_nxt = IDLE;
      GET_ARG:  if (rx_valid)        state_nxt = (cmd == CMD_WRITE) ? WR_DO : RD_ISSUE;
                else if (timeout_hit) state_nxt = IDLE;
      WR_DO:    state_nxt = ACK;
      RD_ISSUE: state_nxt = RD_CAP;
      RD_CAP:   state_nxt = TX_WAIT;
      TX_WAIT:  if (tx_ready) state_nxt = (count == 8'd0) ? IDLE : RD_ISSUE;
      ACK, NAK: if (tx_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; strobes vanish with the asynchronous reset.
  always_comb begin
    reg_we   = (state == WR_DO);
    reg_re   = (state == RD_ISSUE);
    tx_valid = (state == TX_WAIT) || (state == ACK) || (state == NAK);
    busy     = (state != IDLE);
    err      = nak_err || timeout_hit || (rx_valid && !rx_take);
  end

  // Datapath: frame fields, counters and the transmit byte
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      cmd       <= CMD_READ;
      count     <= 8'd0;
      tmo_cnt   <= '0;
      nak_err   <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      tx_data   <= 8'h00;
    end else begin
      nak_err <= 1'b0;

      if (rx_take || !in_frame) tmo_cnt <= '0;
      else                      tmo_cnt <= tmo_cnt + TW'(1);

      unique case (state)
        IDLE: if (rx_valid) begin
          cmd <= cmd_t'(rx_data[1:0]);
          if (illegal_cmd) begin
            nak_err <= 1'b1;
            tx_data <= NAK_BYTE;
          end
        end
        GET_ADDR: if (rx_valid) begin
          reg_addr <= rx_data;
          count    <= 8'd0;          // single read: exactly one access
        end
        GET_ARG: if (rx_valid) begin
          if (cmd == CMD_WRITE) reg_wdata <= rx_data;
          else                  count     <= rx_data;   // LEN: LEN+1 accesses
        end
        WR_DO:  tx_data <= ACK_BYTE;
        RD_CAP: tx_data <= reg_rdata;
        TX_WAIT: if (tx_ready && (count != 8'd0)) begin
          count <= count - 8'd1;
          if (cmd == CMD_INC) reg_addr <= reg_addr + 8'd1;  // wraps FF->00
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_slave.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_slave
//   Directed testbench for uart_cmd_slave. A negedge monitor logs bus reads,
//   writes, transmitted bytes and err pulses; a register-bus model returns
//   (addr ^ 8'hDA) + n for the n-th read of a test, valid only in the cycle
//   after reg_re. Inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_uart_cmd_slave;

  localparam int unsigned TMO = 40;

  logic       MCLK;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       err;

  uart_cmd_slave #(.TIMEOUT(TMO), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
    .MCLK(MCLK), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .busy(busy), .err(err)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int checks   = 0;
  int failures = 0;

  // Monitor state
  int         cyc = 0;
  logic [7:0] re_addr_q[$];
  int         re_cyc_q[$];
  logic [7:0] tx_q[$];
  int         we_cnt, err_cnt, stall_viol, strobe_in_rst;
  logic [7:0] we_addr, we_data;
  logic [7:0] rd_seq, rd_next;
  bit         rd_pending;
  bit         prev_stall;
  logic [7:0] prev_data;

  always @(posedge MCLK) cyc++;

  always @(negedge MCLK) begin
    if (reg_re) begin
      re_addr_q.push_back(reg_addr);
      re_cyc_q.push_back(cyc);
      rd_next    = (reg_addr ^ 8'hDA) + rd_seq;
      rd_seq     = rd_seq + 8'd1;
      rd_pending = 1'b1;
    end
    if (reg_we) begin
      we_cnt++;
      we_addr = reg_addr;
      we_data = reg_wdata;
    end
    if (!reset_n && (reg_re || reg_we || tx_valid || err)) strobe_in_rst++;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (err) err_cnt++;
    if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_viol++;
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  // Read data is only meaningful in the cycle after reg_re.
  always @(posedge MCLK) begin
    #1;
    reg_rdata  = rd_pending ? rd_next : 8'hEE;
    rd_pending = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic clear_mon();
    re_addr_q.delete();
    re_cyc_q.delete();
    tx_q.delete();
    we_cnt = 0; err_cnt = 0; stall_viol = 0; strobe_in_rst = 0;
    we_addr = 8'h00; we_data = 8'h00;
    rd_seq = 8'h00;
  endtask

  // Drives one byte for a single cycle; returns #1 into the following cycle.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    tx_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [28:0] obs;
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    reg_rdata = 8'hEE;
    clear_mon();
    repeat (3) tick();
    obs = {tx_data, reg_addr, reg_wdata, tx_valid, reg_we, reg_re, busy, err};
    checks++;
    if (obs !== 29'h0) begin
      failures++; $display("FAIL reset_values_in_reset: got %h want 0", obs);
    end
    reset_n = 1'b1;
    repeat (2) tick();
    obs = {tx_data, reg_addr, reg_wdata, tx_valid, reg_we, reg_re, busy, err};
    checks++;
    if (obs !== 29'h0) begin
      failures++; $display("FAIL reset_values_after_release: got %h want 0", obs);
    end
  endtask

  task automatic test_single_read();
    bit ok;
    clear_mon();
    tx_ready = 1'b1;
    send_byte(8'h00);
    send_byte(8'h80);                       // ADDR byte was cycle 0; now cycle 1
    checks++;
    if ({reg_re, reg_addr} !== {1'b1, 8'h80}) begin
      failures++; $display("FAIL read_re_cycle1: re=%b addr=%h want re=1 addr=80", reg_re, reg_addr);
    end
    tick();                                 // cycle 2
    checks++;
    if ({reg_re, tx_valid} !== 2'b00) begin
      failures++; $display("FAIL read_cycle2_quiet: re=%b tx_valid=%b want 0 0", reg_re, tx_valid);
    end
    tick();                                 // cycle 3
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h5A}) begin
      failures++; $display("FAIL read_tx_cycle3: valid=%b data=%h want 1 5a", tx_valid, tx_data);
    end
    wait_idle(10, 1'b0, ok);
    checks++;
    if (!ok || re_addr_q.size() != 1 || tx_q.size() != 1 || err_cnt != 0) begin
      failures++;
      $display("FAIL read_summary: idle=%0d reads=%0d tx=%0d errs=%0d want 1 1 1 0",
               ok, re_addr_q.size(), tx_q.size(), err_cnt);
    end
  endtask

  task automatic test_write();
    bit ok;
    clear_mon();
    tx_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h90);
    send_byte(8'h0A);                       // cycle 1 after data byte
    checks++;
    if ({reg_we, reg_re, reg_addr, reg_wdata} !== {2'b10, 8'h90, 8'h0A}) begin
      failures++;
      $display("FAIL write_strobe: we=%b re=%b addr=%h wdata=%h want 1 0 90 0a",
               reg_we, reg_re, reg_addr, reg_wdata);
    end
    tick();                                 // cycle 2
    checks++;
    if ({reg_we, tx_valid, tx_data} !== {2'b01, 8'h06}) begin
      failures++; $display("FAIL write_ack: we=%b valid=%b data=%h want 0 1 06", reg_we, tx_valid, tx_data);
    end
    repeat (4) tick();                      // stall with tx_ready low
    checks++;
    if ({tx_valid, tx_data, busy} !== {1'b1, 8'h06, 1'b1} || stall_viol != 0) begin
      failures++;
      $display("FAIL write_ack_stall: valid=%b data=%h busy=%b viol=%0d want 1 06 1 0",
               tx_valid, tx_data, busy, stall_viol);
    end
    tx_ready = 1'b1;
    wait_idle(10, 1'b0, ok);
    checks++;
    if (!ok || we_cnt != 1 || re_addr_q.size() != 0 || tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
      failures++;
      $display("FAIL write_summary: idle=%0d writes=%0d reads=%0d tx=%0d want 1 1 0 1(06)",
               ok, we_cnt, re_addr_q.size(), tx_q.size());
    end
  endtask

  task automatic test_inc_burst();
    bit ok;
    int bad;
    logic [7:0] a, d;
    clear_mon();
    send_byte(8'h02);
    send_byte(8'hFE);
    send_byte(8'h03);
    wait_idle(300, 1'b1, ok);
    checks++;
    if (!ok || re_addr_q.size() != 4 || tx_q.size() != 4) begin
      failures++;
      $display("FAIL inc_counts: idle=%0d reads=%0d tx=%0d want 1 4 4", ok, re_addr_q.size(), tx_q.size());
    end
    bad = 0;
    a = 8'hFE;
    for (int k = 0; k < 4; k++) begin
      d = (a ^ 8'hDA) + 8'(k);
      if (k >= re_addr_q.size() || k >= tx_q.size() || re_addr_q[k] !== a || tx_q[k] !== d) bad++;
      a = a + 8'd1;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL inc_wrap_order: %0d wrong entries want 0 (addr FE,FF,00,01)", bad);
    end
    checks++;
    if (stall_viol != 0 || err_cnt != 0) begin
      failures++; $display("FAIL inc_stall_stable: viol=%0d errs=%0d want 0 0", stall_viol, err_cnt);
    end
  endtask

  task automatic test_stream_burst();
    bit ok;
    int bad_addr, bad_data, bad_gap;
    clear_mon();
    tx_ready = 1'b1;
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'hC7);
    wait_idle(1000, 1'b0, ok);
    checks++;
    if (!ok || re_addr_q.size() != 200 || tx_q.size() != 200) begin
      failures++;
      $display("FAIL stream_counts: idle=%0d reads=%0d tx=%0d want 1 200 200", ok, re_addr_q.size(), tx_q.size());
    end
    bad_addr = 0; bad_data = 0; bad_gap = 0;
    for (int k = 0; k < re_addr_q.size(); k++) begin
      if (re_addr_q[k] !== 8'h00) bad_addr++;
      if (k > 0 && re_cyc_q[k] - re_cyc_q[k-1] != 3) bad_gap++;
    end
    for (int k = 0; k < tx_q.size(); k++)
      if (tx_q[k] !== 8'hDA + 8'(k)) bad_data++;
    checks++;
    if (bad_addr != 0) begin
      failures++; $display("FAIL stream_addr: %0d reads not at 00, want 0", bad_addr);
    end
    checks++;
    if (bad_data != 0) begin
      failures++; $display("FAIL stream_data: %0d bytes wrong, want 0", bad_data);
    end
    checks++;
    if (bad_gap != 0) begin
      failures++; $display("FAIL stream_spacing: %0d gaps not 3 cycles, want 0", bad_gap);
    end
  endtask

  task automatic test_nak();
    bit ok;
    clear_mon();
    tx_ready = 1'b0;
    send_byte(8'h40);                       // cycle 1: NAK entry
    checks++;
    if ({err, tx_valid, tx_data} !== {2'b11, 8'h15}) begin
      failures++; $display("FAIL nak_entry: err=%b valid=%b data=%h want 1 1 15", err, tx_valid, tx_data);
    end
    tick();
    checks++;
    if ({err, tx_valid, tx_data} !== {2'b01, 8'h15}) begin
      failures++; $display("FAIL nak_err_single: err=%b valid=%b data=%h want 0 1 15", err, tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    wait_idle(10, 1'b0, ok);
    checks++;
    if (!ok || err_cnt != 1 || tx_q.size() != 1 || tx_q[0] !== 8'h15 || re_addr_q.size() != 0 || we_cnt != 0) begin
      failures++;
      $display("FAIL nak_summary: idle=%0d errs=%0d tx=%0d reads=%0d writes=%0d want 1 1 1 0 0",
               ok, err_cnt, tx_q.size(), re_addr_q.size(), we_cnt);
    end
  endtask

  task automatic test_timeout();
    int err_at;
    bit busy_at_err;
    clear_mon();
    tx_ready = 1'b1;
    send_byte(8'h01);
    send_byte(8'h10);                       // last byte cycle 0; now cycle 1
    err_at = -1;
    busy_at_err = 1'b0;
    for (int c = 1; c <= int'(TMO) + 10; c++) begin
      if (err) begin
        err_at = c;
        busy_at_err = busy;
        break;
      end
      tick();
    end
    checks++;
    if (err_at != int'(TMO) || busy_at_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_err_cycle: err at %0d busy=%b want %0d busy=1", err_at, busy_at_err, TMO);
    end
    tick();                                 // cycle TIMEOUT+1
    checks++;
    if ({busy, err} !== 2'b00) begin
      failures++; $display("FAIL timeout_idle: busy=%b err=%b want 0 0", busy, err);
    end
    repeat (3) tick();
    checks++;
    if (we_cnt != 0 || tx_q.size() != 0 || re_addr_q.size() != 0 || err_cnt != 1) begin
      failures++;
      $display("FAIL timeout_no_side_effects: writes=%0d tx=%0d reads=%0d errs=%0d want 0 0 0 1",
               we_cnt, tx_q.size(), re_addr_q.size(), err_cnt);
    end
  endtask

  task automatic test_drop_during_burst();
    bit ok;
    int bad;
    clear_mon();
    tx_ready = 1'b1;
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h04);
    repeat (3) tick();
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    #1;
    checks++;
    if ({err, busy} !== 2'b11) begin
      failures++; $display("FAIL drop_err_pulse: err=%b busy=%b want 1 1", err, busy);
    end
    tick();
    rx_valid = 1'b0;
    wait_idle(100, 1'b0, ok);
    bad = 0;
    for (int k = 0; k < 5; k++)
      if (k >= re_addr_q.size() || k >= tx_q.size() || re_addr_q[k] !== 8'h20 + 8'(k) ||
          tx_q[k] !== ((8'h20 + 8'(k)) ^ 8'hDA) + 8'(k)) bad++;
    checks++;
    if (!ok || bad != 0 || re_addr_q.size() != 5 || tx_q.size() != 5) begin
      failures++;
      $display("FAIL drop_burst_intact: idle=%0d bad=%0d reads=%0d tx=%0d want 1 0 5 5",
               ok, bad, re_addr_q.size(), tx_q.size());
    end
    checks++;
    if (err_cnt != 1) begin
      failures++; $display("FAIL drop_err_count: errs=%0d want 1", err_cnt);
    end
  endtask

  task automatic test_reset_mid_stream();
    bit ok;
    logic [28:0] obs;
    clear_mon();
    tx_ready = 1'b1;
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (100) tick();
    #2 reset_n = 1'b0;                      // asynchronous, mid-cycle
    #1;
    obs = {tx_data, reg_addr, reg_wdata, tx_valid, reg_we, reg_re, busy, err};
    checks++;
    if (obs !== 29'h0) begin
      failures++; $display("FAIL reset_mid_stream_values: got %h want 0", obs);
    end
    repeat (3) tick();
    reset_n = 1'b1;
    checks++;
    if (strobe_in_rst != 0) begin
      failures++; $display("FAIL reset_no_strobes: %0d strobe cycles in reset want 0", strobe_in_rst);
    end
    tick();
    clear_mon();
    send_byte(8'h00);
    send_byte(8'h14);
    wait_idle(20, 1'b0, ok);
    checks++;
    if (!ok || re_addr_q.size() != 1 || re_addr_q[0] !== 8'h14 || tx_q.size() != 1 || tx_q[0] !== 8'hCE) begin
      failures++;
      $display("FAIL reset_then_read: idle=%0d reads=%0d tx=%0d want 1 1(14) 1(ce)",
               ok, re_addr_q.size(), tx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_inc_burst();
    test_stream_burst();
    test_nak();
    test_timeout();
    test_drop_during_burst();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
